// File: rtl/aoi_chain_sweep.sv
// aoi_chain_sweep: registered N-input AOI chain with an exhaustive sweep mode.
// Define AOI_SIG_EN to build the 16-bit output-signature MISR on sig_out.
module aoi_chain_sweep #(
  parameter int N     = 5,
  parameter int DWELL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic         start,
  input  logic [N-1:0] in_vec,
  output logic [N-1:0] pat_out,
  output logic         f_out,
  output logic         pat_valid,
  output logic         busy,
  output logic         done,
  output logic [N:0]   ones_cnt,
  output logic [15:0]  sig_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [N:0] PAT_LAST = {1'b0, {N{1'b1}}};
  localparam logic [N:0] N1_ONE   = {{N{1'b0}}, 1'b1};
  localparam logic [7:0] DW_LAST  = 8'(DWELL - 1);

  // bit0 & bit1, OR'd with the middle terms, gated by the top bit
  function automatic logic aoi(input logic [N-1:0] v);
    logic t;
    t = v[0] & v[1];
    for (int i = 2; i <= N - 2; i++) begin
      t = t | v[i];
    end
    return ~(t & v[N-1]);
  endfunction

  state_t       state_q;
  state_t       state_d;
  logic         accept;
  logic [N:0]   pat_q;
  logic [7:0]   dwell_q;
  logic [N:0]   ones_q;
  logic         pat_f;
  logic         dwell_zero;
  logic         dwell_end;

  assign pat_f      = aoi(pat_q[N-1:0]);
  assign dwell_zero = (dwell_q == 8'd0);
  assign dwell_end  = (dwell_q == DW_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && mode) begin
          state_d = SWEEP;
          accept  = 1'b1;
        end
      end
      SWEEP: begin
        if (pat_q == PAT_LAST && dwell_end) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // pat_q is one bit wider than a pattern so it never wraps mid-sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_out   <= '0;
      f_out     <= 1'b0;
      pat_valid <= 1'b0;
      pat_q     <= '0;
      dwell_q   <= '0;
      ones_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          pat_out   <= in_vec;
          f_out     <= aoi(in_vec);
          pat_valid <= 1'b0;
          if (accept) begin
            pat_q   <= '0;
            dwell_q <= '0;
            ones_q  <= '0;
          end
        end
        SWEEP: begin
          pat_out   <= pat_q[N-1:0];
          f_out     <= pat_f;
          pat_valid <= dwell_zero;
          if (dwell_end) begin
            dwell_q <= '0;
            pat_q   <= pat_q + N1_ONE;
          end else begin
            dwell_q <= dwell_q + 8'd1;
          end
          if (dwell_zero && pat_f) begin
            ones_q <= ones_q + N1_ONE;
          end
        end
        default: begin
          pat_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef AOI_SIG_EN
  logic [15:0] sig_q;
  logic        sig_fb;

  assign sig_fb = sig_q[15] ^ sig_q[13] ^ sig_q[12]
                ^ sig_q[10] ^ pat_f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else if (accept) begin
      sig_q <= '0;
    end else if (state_q == SWEEP && dwell_zero) begin
      sig_q <= {sig_q[14:0], sig_fb};
    end
  end

  assign sig_out = sig_q;
`else
  assign sig_out = 16'h0000;
`endif

  assign ones_cnt = ones_q;
  assign busy     = (state_q == SWEEP);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_aoi_chain_sweep.sv
// tb_aoi_chain_sweep: two instances (N=5/DWELL=4, N=3/DWELL=1) checked
// every cycle against a cycle-index model plus directed literal checks.
module tb_aoi_chain_sweep;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode_i  [2];
  logic start_i [2];
  logic [7:0] vin_i [2];

  logic [4:0]  pat0;
  logic        f0, pv0, busy0, done0;
  logic [5:0]  ones0;
  logic [15:0] sig0;
  logic [2:0]  pat1;
  logic        f1, pv1, busy1, done1;
  logic [3:0]  ones1;
  logic [15:0] sig1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aoi_chain_sweep #(.N(5), .DWELL(4)) u_a (
    .clk(clk), .rst(rst),
    .mode(mode_i[0]), .start(start_i[0]),
    .in_vec(vin_i[0][4:0]),
    .pat_out(pat0), .f_out(f0), .pat_valid(pv0),
    .busy(busy0), .done(done0),
    .ones_cnt(ones0), .sig_out(sig0)
  );

  aoi_chain_sweep #(.N(3), .DWELL(1)) u_b (
    .clk(clk), .rst(rst),
    .mode(mode_i[1]), .start(start_i[1]),
    .in_vec(vin_i[1][2:0]),
    .pat_out(pat1), .f_out(f1), .pat_valid(pv1),
    .busy(busy1), .done(done1),
    .ones_cnt(ones1), .sig_out(sig1)
  );

  int a_pat[2], a_f[2], a_pv[2], a_busy[2];
  int a_done[2], a_ones[2], a_sig[2];

  always_comb begin
    a_pat[0] = int'(pat0);   a_pat[1] = int'(pat1);
    a_f[0] = int'(f0);       a_f[1] = int'(f1);
    a_pv[0] = int'(pv0);     a_pv[1] = int'(pv1);
    a_busy[0] = int'(busy0); a_busy[1] = int'(busy1);
    a_done[0] = int'(done0); a_done[1] = int'(done1);
    a_ones[0] = int'(ones0); a_ones[1] = int'(ones1);
    a_sig[0] = int'(sig0);   a_sig[1] = int'(sig1);
  end

  function automatic int nn(input int i);
    return (i == 0) ? 5 : 3;
  endfunction

  function automatic int dw(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int aoi_m(input int n, input int v);
    int a, b, e, mid;
    a = v & 1;
    b = (v >> 1) & 1;
    e = (v >> (n - 1)) & 1;
    mid = (v >> 2) & ((1 << (n - 3)) - 1);
    return (((a & b) != 0 || mid != 0) && e != 0) ? 0 : 1;
  endfunction

  function automatic int misr_m(input int s, input int f);
    int fb;
    fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10) ^ f) & 1;
    return ((s << 1) & 16'hFFFF) | fb;
  endfunction

  task automatic chk(input string nm, input int i,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0d want=%0d",
               nm, i, act, exp);
    end
  endtask

  // model: phase 0 idle, 1 sweep (k = cycle index), 2 done
  int ph[2], k[2];
  int m_pat[2], m_f[2], m_pv[2], m_ones[2], m_sig[2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      int p, d, fv;
      if (rst) begin
        ph[i] <= 0; k[i] <= 0;
        m_pat[i] <= 0; m_f[i] <= 0; m_pv[i] <= 0;
        m_ones[i] <= 0; m_sig[i] <= 0;
      end else if (ph[i] == 0) begin
        m_pat[i] <= int'(vin_i[i]) & ((1 << nn(i)) - 1);
        m_f[i] <= aoi_m(nn(i), int'(vin_i[i]));
        m_pv[i] <= 0;
        if (start_i[i] && mode_i[i]) begin
          ph[i] <= 1; k[i] <= 0;
          m_ones[i] <= 0; m_sig[i] <= 0;
        end
      end else if (ph[i] == 1) begin
        p = k[i] / dw(i);
        d = k[i] % dw(i);
        fv = aoi_m(nn(i), p);
        m_pat[i] <= p;
        m_f[i] <= fv;
        m_pv[i] <= (d == 0) ? 1 : 0;
        if (d == 0) begin
          m_ones[i] <= m_ones[i] + fv;
          m_sig[i] <= misr_m(m_sig[i], fv);
        end
        k[i] <= k[i] + 1;
        if (k[i] == (1 << nn(i)) * dw(i) - 1) ph[i] <= 2;
      end else begin
        m_pv[i] <= 0;
        ph[i] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int wsig;
`ifdef AOI_SIG_EN
      wsig = m_sig[i];
`else
      wsig = 0;
`endif
      chk("pat_out", i, a_pat[i], m_pat[i]);
      chk("f_out", i, a_f[i], m_f[i]);
      chk("pat_valid", i, a_pv[i], m_pv[i]);
      chk("busy", i, a_busy[i], (ph[i] == 1) ? 1 : 0);
      chk("done", i, a_done[i], (ph[i] == 2) ? 1 : 0);
      chk("ones_cnt", i, a_ones[i], m_ones[i]);
      chk("sig_out", i, a_sig[i], wsig);
    end
  end

  task automatic run_sweep(input int i, input bit disturb,
                           output int busy_n, output int pv_n,
                           output int ord_err, output int fz_n,
                           output int fz_pat, output int done_n);
    int cyc;
    busy_n = 0; pv_n = 0; ord_err = 0;
    fz_n = 0; fz_pat = -1; done_n = 0; cyc = 0;
    @(negedge clk);
    mode_i[i] = 1'b1;
    start_i[i] = 1'b1;
    @(negedge clk);
    start_i[i] = 1'b0;
    while (done_n == 0 && cyc < 600) begin
      if (a_pv[i] != 0) begin
        if (a_pat[i] != pv_n) ord_err++;
        if (a_f[i] == 0) begin
          fz_n++;
          fz_pat = a_pat[i];
        end
        pv_n++;
      end
      if (a_busy[i] != 0) busy_n++;
      if (a_done[i] != 0) done_n++;
      if (disturb) begin
        if (cyc == 40) begin
          start_i[i] = 1'b1;
          mode_i[i] = 1'b0;
          vin_i[i] = 8'($urandom);
        end
        if (cyc == 41) start_i[i] = 1'b0;
        if (cyc == 60) begin
          start_i[i] = 1'b1;
          mode_i[i] = 1'b1;
        end
        if (cyc == 61) start_i[i] = 1'b0;
      end
      cyc++;
      if (done_n == 0) @(negedge clk);
    end
  endtask

  task automatic all_zero(input int i);
    chk("rst_pat_out", i, a_pat[i], 0);
    chk("rst_f_out", i, a_f[i], 0);
    chk("rst_pat_valid", i, a_pv[i], 0);
    chk("rst_busy", i, a_busy[i], 0);
    chk("rst_done", i, a_done[i], 0);
    chk("rst_ones", i, a_ones[i], 0);
    chk("rst_sig", i, a_sig[i], 0);
  endtask

  initial begin
    int bn, pn, oe, fz, fp, dn, sg1, sg2, dseen;
    for (int i = 0; i < 2; i++) begin
      mode_i[i] = 1'b0;
      start_i[i] = 1'b0;
      vin_i[i] = 8'd0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    all_zero(0);
    all_zero(1);
    rst = 1'b0;

    // direct evaluation literals
    vin_i[0] = 8'b10011;
    @(negedge clk);
    chk("lit_f_10011", 0, a_f[0], 0);
    chk("lit_pat_10011", 0, a_pat[0], 5'b10011);
    vin_i[0] = 8'b01100;
    @(negedge clk);
    chk("lit_f_01100", 0, a_f[0], 1);

    // start with mode 0 is ignored
    start_i[0] = 1'b1;
    mode_i[0] = 1'b0;
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mode0_busy", 0, a_busy[0], 0);
    end

    run_sweep(0, 1'b0, bn, pn, oe, fz, fp, dn);
    chk("a_done", 0, dn, 1);
    chk("a_busy_len", 0, bn, 128);
    chk("a_pv_count", 0, pn, 32);
    chk("a_order", 0, oe, 0);
    chk("a_zero_pats", 0, fz, 13);
    chk("a_ones", 0, a_ones[0], 19);
    sg1 = a_sig[0];
    mode_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_ones_hold", 0, a_ones[0], 19);
    chk("a_sig_hold", 0, a_sig[0], sg1);

    // start re-pulsed and mode toggled mid-sweep
    run_sweep(0, 1'b1, bn, pn, oe, fz, fp, dn);
    chk("d_done", 0, dn, 1);
    chk("d_busy_len", 0, bn, 128);
    chk("d_pv_count", 0, pn, 32);
    chk("d_order", 0, oe, 0);
    chk("d_ones", 0, a_ones[0], 19);
    sg2 = a_sig[0];
    mode_i[0] = 1'b0;
`ifdef AOI_SIG_EN
    chk("sig_nonzero", 0, (sg1 != 0) ? 1 : 0, 1);
    chk("sig_repeat", 0, sg2, sg1);
`else
    chk("sig_off_1", 0, sg1, 0);
    chk("sig_off_2", 0, sg2, 0);
`endif

    // N=3, DWELL=1
    run_sweep(1, 1'b0, bn, pn, oe, fz, fp, dn);
    chk("b_done", 1, dn, 1);
    chk("b_busy_len", 1, bn, 8);
    chk("b_pv_count", 1, pn, 8);
    chk("b_order", 1, oe, 0);
    chk("b_zero_pats", 1, fz, 1);
    chk("b_zero_pat", 1, fp, 7);
    chk("b_ones", 1, a_ones[1], 7);
    mode_i[1] = 1'b0;

    // reset mid-sweep aborts without a done pulse
    @(negedge clk);
    mode_i[0] = 1'b1;
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    mode_i[0] = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1 all_zero(0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dseen = 0;
    repeat (200) begin
      @(negedge clk);
      if (a_done[0] != 0 || a_busy[0] != 0) dseen++;
    end
    chk("abort_no_done", 0, dseen, 0);

    run_sweep(0, 1'b0, bn, pn, oe, fz, fp, dn);
    chk("r_done", 0, dn, 1);
    chk("r_busy_len", 0, bn, 128);
    chk("r_ones", 0, a_ones[0], 19);
    mode_i[0] = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
